// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, reset constants,
// fetch FSM encoding and redirect-target helpers.
package fetch_stage_pkg;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  // J-format: keep the region bits of the link address, word-align the field.
  function automatic logic [15:0] jump_target(input logic [15:0] link_pc,
                                              input logic [12:0] jump_addr);
    return {link_pc[15:14], jump_addr, 1'b0};
  endfunction

  function automatic logic [15:0] branch_align(input logic [15:0] target);
    return {target[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Combinational next-PC selection: sequential successor plus the highest
// priority redirect (taken branch over jump).
module pc_next_sel
  import fetch_stage_pkg::*;
(
  input  logic        [15:0] pc,
  input  logic        [15:0] link_pc,
  input  logic               jump_en,
  input  logic        [12:0] jump_addr,
  input  logic               branch_taken,
  input  logic        [15:0] branch_target,
  output logic        [15:0] seq_pc,
  output logic        [15:0] target,
  output logic               redirect
);

  assign seq_pc = pc + 16'd2;

  always_comb begin
    target   = seq_pc;
    redirect = 1'b0;
    if (branch_taken) begin
      target   = branch_align(branch_target);
      redirect = 1'b1;
    end else if (jump_en) begin
      target   = jump_target(link_pc, jump_addr);
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a variable-latency instruction memory and
// fills the IF/ID register, honouring decode stalls and branch/jump redirects.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [12:0] jump_addr,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid
);

  fetch_state_t state;
  logic [15:0]  pc_q;
  logic [15:0]  hold_buf;
  logic [15:0]  seq_pc;
  logic [15:0]  redir_target;
  logic         redirect;

  pc_next_sel u_pc_next_sel (
    .pc            (pc_q),
    .link_pc       (if_id_pc_plus2),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .seq_pc        (seq_pc),
    .target        (redir_target),
    .redirect      (redirect)
  );

  assign pc        = pc_q;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pc_q           <= RESET_PC;
      imem_req       <= 1'b0;
      hold_buf       <= NOP_INSTR;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus2 <= 16'h0000;
      if_id_valid    <= 1'b0;
    end else begin
      // Every redirect flushes IF/ID and retargets pc; the state arms below
      // only decide how the memory handshake continues.
      if (redirect) begin
        pc_q        <= redir_target;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (redirect) begin
            // A response still in flight must be drained before refetching.
            state    <= imem_ready ? FETCH : DISCARD;
            imem_req <= imem_ready;
          end else if (imem_ready && stall) begin
            hold_buf <= imem_rdata;
            state    <= HOLD;
            imem_req <= 1'b0;
          end else if (imem_ready) begin
            if_id_instr    <= imem_rdata;
            if_id_pc_plus2 <= seq_pc;
            if_id_valid    <= 1'b1;
            pc_q           <= seq_pc;
          end else if (!stall) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            hold_buf <= NOP_INSTR;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (!stall) begin
            if_id_instr    <= hold_buf;
            if_id_pc_plus2 <= seq_pc;
            if_id_valid    <= 1'b1;
            pc_q           <= seq_pc;
            state          <= FETCH;
            imem_req       <= 1'b1;
          end
        end
        DISCARD: begin
          if (!redirect && !stall) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
          if (imem_ready) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID contents.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump_en;
  logic [12:0] jump_addr;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input fetch_state_t exp);
    check(tag, {14'b0, dut.state}, {14'b0, exp});
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {15'b0, if_id_valid}, 16'h0000);
    check({tag, "_instr"}, if_id_instr, NOP_INSTR);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard, expected a queued word", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, {15'b0, if_id_valid}, 16'h0001);
      check({tag, "_instr"}, if_id_instr, e.instr);
      check({tag, "_pc2"}, if_id_pc_plus2, e.pc2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc, RESET_PC);
    check({tag, "_req"}, {15'b0, imem_req}, 16'h0000);
    check({tag, "_instr"}, if_id_instr, NOP_INSTR);
    check({tag, "_pc2"}, if_id_pc_plus2, 16'h0000);
    check({tag, "_valid"}, {15'b0, if_id_valid}, 16'h0000);
    check_state({tag, "_state"}, IDLE);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    jump_en       = 1'b0;
    jump_addr     = 13'h0000;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    imem_ready    = 1'b0;
    imem_rdata    = 16'h0000;

    // Reset values
    #1;
    check_reset_outputs("rst0");
    step();
    rst = 1'b0;
    step();
    check_state("idle_to_fetch", FETCH);
    check("fetch_req", {15'b0, imem_req}, 16'h0001);
    check("fetch_addr", imem_addr, 16'h0000);

    // Back-to-back fetches with memory always ready
    imem_ready = 1'b1;
    imem_rdata = 16'h1A01; sb.push_back('{16'h1A01, 16'h0002});
    step(); check_sb("seqA"); check("seqA_pc", pc, 16'h0002);
    imem_rdata = 16'h2B02; sb.push_back('{16'h2B02, 16'h0004});
    step(); check_sb("seqB"); check("seqB_pc", pc, 16'h0004);
    imem_rdata = 16'h3C03; sb.push_back('{16'h3C03, 16'h0006});
    step(); check_sb("seqC"); check("seqC_pc", pc, 16'h0006);

    // Three-cycle memory latency
    imem_ready = 1'b0;
    imem_rdata = 16'hD00D;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lat_addr", imem_addr, 16'h0006);
      check("lat_req", {15'b0, imem_req}, 16'h0001);
      check_bubble("lat_bubble");
    end
    imem_ready = 1'b1; sb.push_back('{16'hD00D, 16'h0008});
    step(); check_sb("latD"); check("latD_pc", pc, 16'h0008);

    // Word arrives during a two-cycle stall
    imem_rdata = 16'hE00E; stall = 1'b1;
    step();
    imem_ready = 1'b0;
    check_state("hold1_state", HOLD);
    check("hold1_pc", pc, 16'h0008);
    check("hold1_instr", if_id_instr, 16'hD00D);
    check("hold1_req", {15'b0, imem_req}, 16'h0000);
    step();
    check_state("hold2_state", HOLD);
    check("hold2_instr", if_id_instr, 16'hD00D);
    check("hold2_valid", {15'b0, if_id_valid}, 16'h0001);
    stall = 1'b0; sb.push_back('{16'hE00E, 16'h000A});
    step(); check_sb("holdE"); check("holdE_pc", pc, 16'h000A);
    check_state("holdE_state", FETCH);

    // Branch with ready data: odd target aligned, data dropped
    imem_ready = 1'b1; imem_rdata = 16'hBAD0;
    branch_taken = 1'b1; branch_target = 16'h4005;
    step();
    branch_taken = 1'b0;
    check("br_pc", pc, 16'h4004);
    check_bubble("br_bubble");
    check_state("br_state", FETCH);
    imem_rdata = 16'h4100; sb.push_back('{16'h4100, 16'h4006});
    step(); check_sb("jinstr");

    // Jump using if_id_pc_plus2 region bits
    jump_en = 1'b1; jump_addr = 13'h0100; imem_rdata = 16'hBAD1;
    step();
    jump_en = 1'b0;
    check("jmp_pc", pc, 16'h4200);
    check_bubble("jmp_bubble");
    imem_rdata = 16'h5155; sb.push_back('{16'h5155, 16'h4202});
    step(); check_sb("jmpH"); check("jmpH_pc", pc, 16'h4202);

    // Branch beats jump while the request is outstanding
    imem_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 16'h0020;
    jump_en = 1'b1; jump_addr = 13'h1FFF; stall = 1'b1;
    step();
    branch_taken = 1'b0; jump_en = 1'b0; stall = 1'b0;
    check_state("disc_state", DISCARD);
    check("disc_pc", pc, 16'h0020);
    check("disc_req", {15'b0, imem_req}, 16'h0000);
    check_bubble("disc_bubble");
    step();
    check_state("disc2_state", DISCARD);
    check("disc2_req", {15'b0, imem_req}, 16'h0000);
    imem_ready = 1'b1; imem_rdata = 16'hDEAD;
    step();
    check_state("disc_done", FETCH);
    check_bubble("late_drop");
    check("refetch_addr", imem_addr, 16'h0020);
    imem_rdata = 16'h6A6A; sb.push_back('{16'h6A6A, 16'h0022});
    step(); check_sb("newI"); check("newI_pc", pc, 16'h0022);

    // PC wraps modulo 2^16; stall with no data keeps IF/ID
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    step();
    branch_taken = 1'b0;
    check("wrap_br_pc", pc, 16'hFFFE);
    imem_rdata = 16'h7777; sb.push_back('{16'h7777, 16'h0000});
    step(); check_sb("wrapJ"); check("wrap_pc", pc, 16'h0000);
    imem_ready = 1'b0; stall = 1'b1;
    step();
    check("stall_keep_instr", if_id_instr, 16'h7777);
    check("stall_keep_valid", {15'b0, if_id_valid}, 16'h0001);

    // Asynchronous reset in the middle of HOLD
    imem_ready = 1'b1; imem_rdata = 16'h8888;
    step();
    imem_ready = 1'b0;
    check_state("pre_rst_hold", HOLD);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    stall = 1'b0; imem_ready = 1'b1; imem_rdata = 16'h9999;
    step();
    check_reset_outputs("rst_held");
    rst = 1'b0; imem_rdata = 16'hABCD;
    step();
    check_state("restart_state", FETCH);
    check("restart_pc", pc, 16'h0000);
    check_bubble("restart_bubble");
    sb.push_back('{16'hABCD, 16'h0002});
    step(); check_sb("restartL"); check("restartL_pc", pc, 16'h0002);

    check("sb_drained", sb.size()[15:0], 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
